// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit feeder slice.
//   DEPTH_LOG2_DEFAULT : default log2 of the feeder FIFO depth (16 entries)
//   tx_state_e         : feeder FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,   // nothing in flight, may launch a byte
        ST_WAIT = 1'b1    // frame in flight, waiting for tx_done
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_feeder_if.sv
// ----------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles the host write side and the transceiver side of uart_tx_feeder.
//   wr_en, wr_data   : host push request and byte
//   full, empty      : FIFO occupancy flags
//   level            : FIFO entry count (DEPTH_LOG2+1 bits)
//   tx_data, tx_wr   : byte and one-cycle start pulse to the transceiver
//   tx_done          : one-cycle end-of-frame pulse from the transceiver
//   idle             : FIFO empty and no frame in flight
//   ovf, ovf_clr     : sticky overflow flag and its clear (only with
//                      UART_TX_OVERFLOW_EN defined)
// Modports: slave = the feeder, master = the host/transceiver side.
// ----------------------------------------------------------------------------
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
);

    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            tx_data;
    logic                  tx_wr;
    logic                  tx_done;
    logic                  idle;
`ifdef UART_TX_OVERFLOW_EN
    logic                  ovf;
    logic                  ovf_clr;
`endif

    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, level, tx_data, tx_wr, idle
`ifdef UART_TX_OVERFLOW_EN
        , input ovf_clr, output ovf
`endif
    );

    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, level, tx_data, tx_wr, idle
`ifdef UART_TX_OVERFLOW_EN
        , output ovf_clr, input ovf
`endif
    );

endinterface : uart_tx_feeder_if

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular byte FIFO with registered level counter.
//   sys_clk  : clock, rising edge
//   sys_rst  : synchronous active-high reset (pointers and level only)
//   wr_en    : push request; dropped while full
//   wr_data  : byte to push
//   rd_en    : pop request; ignored while empty
//   rd_data  : byte at the read pointer (combinational, valid when !empty)
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : entry count
// ----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                    DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  push;
    logic                  pop;

    assign full  = (level_q == LVL_MAX);
    assign empty = (level_q == '0);
    assign level = level_q;

    // A push while full is dropped outright, even if a pop happens too.
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr_q];

    // Pointers wrap modulo DEPTH through natural overflow of DEPTH_LOG2 bits.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; only pointers and
    // level define validity, and an unreset array maps onto plain RAM.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// uart_tx_feeder
// Queues bytes in a FIFO and hands them one at a time to a UART transceiver:
// a registered one-cycle tx_wr launches a byte, tx_done ends the frame, and
// the next byte follows after a one-cycle gap.
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset; flushes queue and in-flight byte
//   bus     : uart_tx_feeder_if.slave (write side, transceiver side, status)
// Optional feature macro: UART_TX_OVERFLOW_EN adds sticky bus.ovf with
// bus.ovf_clr (set on any dropped push, set wins over clear).
// ----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    uart_tx_feeder_if.slave         bus
);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic                  pop;
    logic [7:0]            fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  tx_wr_q;
    logic [7:0]            tx_data_q;

    uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state. tx_done outside WAIT has no effect.
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
            ST_WAIT: if (bus.tx_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: launch only from IDLE, which forces the one-cycle gap
    // after tx_done because WAIT always returns through IDLE.
    always_comb begin
        pop = 1'b0;
        if (state_q == ST_IDLE && !fifo_empty) pop = 1'b1;
    end

    // Registered transceiver outputs; tx_data holds through the frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_wr_q <= pop;
            if (pop) tx_data_q <= fifo_rd_data;
        end
    end

    assign bus.tx_wr   = tx_wr_q;
    assign bus.tx_data = tx_data_q;
    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;
    assign bus.level   = fifo_level;
    assign bus.idle    = (state_q == ST_IDLE) && fifo_empty;

`ifdef UART_TX_OVERFLOW_EN
    logic push_drop;
    logic ovf_q;

    assign push_drop = bus.wr_en & fifo_full;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)          ovf_q <= 1'b0;
        else if (push_drop)   ovf_q <= 1'b1;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`endif

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed self-checking bench for uart_tx_feeder. Inputs change on the
// falling edge; outputs are sampled on the falling edge, half a cycle after
// the rising edge that updated them.
// ----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    uart_tx_feeder_if bus ();

    uart_tx_feeder dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en   = 1'b0;
    endtask

    // Called in WAIT: end the frame, expect one quiet cycle, then launch of b.
    task automatic done_then_expect(input logic [7:0] b, input string tag);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        check({tag, "_gap"}, bus.tx_wr, 1'b0);
        step();
        check({tag, "_wr"}, bus.tx_wr, 1'b1);
        check({tag, "_data"}, bus.tx_data, b);
        step();
        check({tag, "_wr_low"}, bus.tx_wr, 1'b0);
    endtask

    task automatic end_frame();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int         sent;
        int         got;
        int         dly;
        int         pulses;
        bit         busy;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_done = 1'b0;
`ifdef UART_TX_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif

        // Reset state.
        step();
        step();
        check("rst_full",    bus.full,    1'b0);
        check("rst_empty",   bus.empty,   1'b1);
        check("rst_idle",    bus.idle,    1'b1);
        check("rst_tx_wr",   bus.tx_wr,   1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_level",   bus.level,   0);
`ifdef UART_TX_OVERFLOW_EN
        check("rst_ovf",     bus.ovf,     1'b0);
`endif
        sys_rst = 1'b0;
        step();

        // Single byte: tx_wr two cycles after the write.
        push(8'hA5);
        check("single_wr_early", bus.tx_wr, 1'b0);
        check("single_level1",   bus.level, 1);
        check("single_busy",     bus.idle,  1'b0);
        step();
        check("single_wr",       bus.tx_wr,   1'b1);
        check("single_data",     bus.tx_data, 8'hA5);
        check("single_level0",   bus.level,   0);
        check("single_idle_wr",  bus.idle,    1'b0);
        step();
        check("single_pulse1",   bus.tx_wr,   1'b0);
        check("single_hold",     bus.tx_data, 8'hA5);
        repeat (3) step();
        check("single_wait_idle", bus.idle,  1'b0);
        check("single_wait_wr",   bus.tx_wr, 1'b0);
        end_frame();
        check("single_done_idle", bus.idle,  1'b1);

        // Stray tx_done in IDLE has no effect.
        end_frame();
        step();
        check("stray_done_idle", bus.idle,  1'b1);
        check("stray_done_wr",   bus.tx_wr, 1'b0);

        // Ordering and back-to-back launches.
        bus.wr_en = 1'b1; bus.wr_data = 8'h01;
        step();
        bus.wr_data = 8'h02;
        step();
        check("b2b_wr1",   bus.tx_wr,   1'b1);
        check("b2b_data1", bus.tx_data, 8'h01);
        bus.wr_data = 8'h03;
        step();
        bus.wr_en = 1'b0;
        check("b2b_wr1_low", bus.tx_wr, 1'b0);
        check("b2b_level2",  bus.level, 2);
        done_then_expect(8'h02, "b2b2");
        done_then_expect(8'h03, "b2b3");
        end_frame();
        check("b2b_idle", bus.idle, 1'b1);

        // Fill and overflow with the first byte in flight.
        push(8'hA0);
        step();
        check("fill_launch", bus.tx_wr, 1'b1);
        for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
        check("fill_level16", bus.level, 16);
        check("fill_full",    bus.full,  1'b1);
        check("fill_empty",   bus.empty, 1'b0);
        push(8'hC0);
        check("ovf_drop_level", bus.level, 16);
        check("ovf_drop_full",  bus.full,  1'b1);
`ifdef UART_TX_OVERFLOW_EN
        check("ovf_set", bus.ovf, 1'b1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", bus.ovf, 1'b0);
        bus.ovf_clr = 1'b1;
        push(8'hC1);
        bus.ovf_clr = 1'b0;
        check("ovf_set_wins", bus.ovf, 1'b1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr2", bus.ovf, 1'b0);
`endif
        for (int i = 0; i < 16; i++) done_then_expect(8'hB0 + 8'(i), "fill_drain");
        end_frame();
        check("fill_end_idle",  bus.idle,  1'b1);
        check("fill_end_level", bus.level, 0);

        // Simultaneous push and pop at level 5.
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        check("simul_level_pre", bus.level, 5);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'hD6;
        step();
        bus.wr_en = 1'b0;
        check("simul_level", bus.level,   5);
        check("simul_wr",    bus.tx_wr,   1'b1);
        check("simul_data",  bus.tx_data, 8'hD1);
        for (int i = 2; i < 7; i++) done_then_expect(8'hD0 + 8'(i), "simul_drain");
        end_frame();
        check("simul_end_idle", bus.idle, 1'b1);

        // Wrap-around stream with random tx_done delays.
        sent = 0; got = 0; busy = 1'b0; dly = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.tx_wr) begin
                check("wrap_no_overlap", busy, 1'b0);
                if (exp_q.size() == 0) check("wrap_unexpected_wr", 1'b1, 1'b0);
                else check("wrap_data", bus.tx_data, exp_q.pop_front());
                got++;
                busy = 1'b1;
                dly  = int'($urandom_range(0, 4));
            end
            check("wrap_level", bus.level, exp_q.size());
            bus.tx_done = 1'b0;
            if (busy) begin
                if (dly == 0) begin
                    bus.tx_done = 1'b1;
                    busy = 1'b0;
                end else dly--;
            end
            bus.wr_en = 1'b0;
            if (sent < 40 && exp_q.size() < 14 && $urandom_range(0, 1) == 1) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'h40 + 8'(sent);
                exp_q.push_back(8'h40 + 8'(sent));
                sent++;
            end
            step();
            if (got == 40 && !busy) break;
        end
        bus.tx_done = 1'b0;
        bus.wr_en   = 1'b0;
        step();
        check("wrap_count", got, 40);
        check("wrap_level0", bus.level, 0);
        check("wrap_idle",   bus.idle,  1'b1);

        // Reset mid-frame with four queued bytes.
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
        check("midrst_level_pre", bus.level, 4);
        check("midrst_busy_pre",  bus.idle,  1'b0);
        sys_rst = 1'b1;
        step();
        check("midrst_empty",   bus.empty,   1'b1);
        check("midrst_idle",    bus.idle,    1'b1);
        check("midrst_tx_wr",   bus.tx_wr,   1'b0);
        check("midrst_level",   bus.level,   0);
        check("midrst_tx_data", bus.tx_data, 8'h00);
        sys_rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx_wr) pulses++;
        end
        check("midrst_no_wr", pulses, 0);
        check("midrst_still_idle", bus.idle, 1'b1);
        push(8'h77);
        check("post_rst_wr_early", bus.tx_wr, 1'b0);
        step();
        check("post_rst_wr",   bus.tx_wr,   1'b1);
        check("post_rst_data", bus.tx_data, 8'h77);
        end_frame();
        check("post_rst_idle", bus.idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_feeder
